// File: rtl/coherence_bus_if.sv
// Bundle of per-core cache-controller bus signals and the unified-memory port.
// The controller takes the slave modport; the cores/memory side take master.
interface coherence_bus_if #(
  parameter int unsigned TAG_W   = 13,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned UADDR_W = 11
);
  logic [1:0]           read_miss;
  logic [1:0]           write_miss;
  logic [1:0]           invalidate;
  logic [3:0]           block_state;
  logic [2*TAG_W-1:0]   BICO;
  logic [1:0]           cpu_search_found;
  logic [2*UADDR_W-1:0] u_addr;
  logic [1:0]           u_re;
  logic [1:0]           u_we;
  logic [2*LINE_W-1:0]  d_line;

  logic [1:0]           grant;
  logic [1:0]           cpu_search;
  logic [2*TAG_W-1:0]   BOCI;
  logic [3:0]           cpu_datasel;
  logic [1:0]           invalidate_from_other_cpu;
  logic [1:0]           u_rdy;
  logic [LINE_W-1:0]    u_rd_data;

  logic [UADDR_W-1:0]   mem_addr;
  logic                 mem_re;
  logic                 mem_we;
  logic [LINE_W-1:0]    mem_wdata;
  logic [LINE_W-1:0]    mem_rdata;
  logic                 mem_rdy;

  modport slave (
    input  read_miss, write_miss, invalidate, block_state, BICO, cpu_search_found,
    input  u_addr, u_re, u_we, d_line, mem_rdata, mem_rdy,
    output grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu, u_rdy,
    output u_rd_data, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output read_miss, write_miss, invalidate, block_state, BICO, cpu_search_found,
    output u_addr, u_re, u_we, d_line, mem_rdata, mem_rdy,
    input  grant, cpu_search, BOCI, cpu_datasel, invalidate_from_other_cpu, u_rdy,
    input  u_rd_data, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core snooping-bus controller: round-robin arbitration, peer snoop and
// invalidate, data-source selection and muxing of the granted core onto memory.
module coherence_bus_ctrl #(
  parameter int unsigned NCPU    = 2,
  parameter int unsigned TAG_W   = 13,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned UADDR_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  coherence_bus_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StSnoop, StResp, StGrant} state_e;
  typedef enum logic [1:0] {TyRead, TyWrite, TyInv} op_e;

  localparam logic [1:0] DsNone = 2'b00;
  localparam logic [1:0] DsMem  = 2'b01;
  localparam logic [1:0] DsPeer = 2'b10;

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             rr_q, rr_d;
  logic             win_q, win_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [1:0]       datasel_q, datasel_d;

  logic [NCPU-1:0]  req;
  logic [1:0]       win_oh, peer_oh;
  logic             peer_found;
  logic [1:0]       peer_state;
  logic [1:0]       resp_sel;

  assign req        = bus.read_miss | bus.write_miss | bus.invalidate;
  assign win_oh     = win_q ? 2'b10 : 2'b01;
  assign peer_oh    = ~win_oh;
  assign peer_found = win_q ? bus.cpu_search_found[0] : bus.cpu_search_found[1];
  assign peer_state = win_q ? bus.block_state[1:0] : bus.block_state[3:2];

  // Only a modified peer copy is fresher than memory.
  assign resp_sel = (op_q == TyInv) ? DsNone :
                    (peer_found && peer_state == 2'b10) ? DsPeer : DsMem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= TyRead;
      rr_q      <= 1'b0;
      win_q     <= 1'b0;
      tag_q     <= '0;
      datasel_q <= DsNone;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      tag_q     <= tag_d;
      datasel_q <= datasel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rr_d      = rr_q;
    win_d     = win_q;
    tag_d     = tag_q;
    datasel_d = datasel_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          // On contention rr_q names the winner and then points at the loser.
          if (&req) begin
            win_d = rr_q;
            rr_d  = ~rr_q;
          end else begin
            win_d = req[1];
          end
          tag_d = win_d ? bus.BICO[2*TAG_W-1:TAG_W] : bus.BICO[TAG_W-1:0];
          if (bus.write_miss[win_d])     op_d = TyWrite;
          else if (bus.read_miss[win_d]) op_d = TyRead;
          else                           op_d = TyInv;
          state_d = StSnoop;
        end
      end
      StSnoop: state_d = StResp;
      StResp: begin
        datasel_d = resp_sel;
        state_d   = StGrant;
      end
      StGrant: begin
        if (!req[win_q]) begin
          datasel_d = DsNone;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.grant                     = '0;
    bus.cpu_search                = '0;
    bus.BOCI                      = '0;
    bus.cpu_datasel               = '0;
    bus.invalidate_from_other_cpu = '0;
    bus.u_rdy                     = '0;
    bus.u_rd_data                 = bus.mem_rdata;
    bus.mem_addr                  = '0;
    bus.mem_re                    = 1'b0;
    bus.mem_we                    = 1'b0;
    bus.mem_wdata                 = '0;
    unique case (state_q)
      StSnoop: begin
        bus.cpu_search = peer_oh;
        bus.BOCI       = {{TAG_W{peer_oh[1]}} & tag_q, {TAG_W{peer_oh[0]}} & tag_q};
      end
      StResp: begin
        bus.BOCI        = {{TAG_W{peer_oh[1]}} & tag_q, {TAG_W{peer_oh[0]}} & tag_q};
        bus.cpu_datasel = {{2{win_oh[1]}} & resp_sel, {2{win_oh[0]}} & resp_sel};
        if (op_q != TyRead && peer_found) bus.invalidate_from_other_cpu = peer_oh;
      end
      StGrant: begin
        bus.grant       = win_oh;
        bus.cpu_datasel = {{2{win_oh[1]}} & datasel_q, {2{win_oh[0]}} & datasel_q};
        bus.u_rdy       = win_oh & {2{bus.mem_rdy}};
        bus.mem_addr    = win_q ? bus.u_addr[2*UADDR_W-1:UADDR_W] : bus.u_addr[UADDR_W-1:0];
        bus.mem_re      = win_q ? bus.u_re[1] : bus.u_re[0];
        bus.mem_we      = win_q ? bus.u_we[1] : bus.u_we[0];
        bus.mem_wdata   = win_q ? bus.d_line[2*LINE_W-1:LINE_W] : bus.d_line[LINE_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed bench for coherence_bus_ctrl: snoop timing, data source, invalidates,
// memory muxing, round-robin arbitration and asynchronous reset.
module tb_coherence_bus_ctrl;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  coherence_bus_if #(.TAG_W(13), .LINE_W(64), .UADDR_W(11)) bus ();

  coherence_bus_ctrl #(.NCPU(2), .TAG_W(13), .LINE_W(64), .UADDR_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"},  64'(bus.grant), 64'h0);
    check({tag, "_search"}, 64'(bus.cpu_search), 64'h0);
    check({tag, "_boci"},   64'(bus.BOCI), 64'h0);
    check({tag, "_dsel"},   64'(bus.cpu_datasel), 64'h0);
    check({tag, "_inv"},    64'(bus.invalidate_from_other_cpu), 64'h0);
    check({tag, "_urdy"},   64'(bus.u_rdy), 64'h0);
    check({tag, "_maddr"},  64'(bus.mem_addr), 64'h0);
    check({tag, "_mre"},    64'(bus.mem_re), 64'h0);
    check({tag, "_mwe"},    64'(bus.mem_we), 64'h0);
    check({tag, "_mwdata"}, bus.mem_wdata, 64'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [1:0] rr_exp [3];
    rr_exp[0] = 2'b01;
    rr_exp[1] = 2'b10;
    rr_exp[2] = 2'b01;
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    bus.read_miss        = '0;
    bus.write_miss       = '0;
    bus.invalidate       = '0;
    bus.block_state      = '0;
    bus.BICO             = '0;
    bus.cpu_search_found = '0;
    bus.u_addr           = '0;
    bus.u_re             = '0;
    bus.u_we             = '0;
    bus.d_line           = '0;
    bus.mem_rdata        = '0;
    bus.mem_rdy          = 1'b0;
    #3;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_idle("idle");

    // Core 0 read miss, peer misses: memory is the source, no invalidate.
    bus.BICO      = {13'h0, 13'h0A5};
    bus.read_miss = 2'b01;
    tick();
    check("t1_search", 64'(bus.cpu_search), 64'h2);
    check("t1_boci1",  64'(bus.BOCI[25:13]), 64'h0A5);
    check("t1_boci0",  64'(bus.BOCI[12:0]), 64'h0);
    check("t1_grant_snoop", 64'(bus.grant), 64'h0);
    tick();
    check("t1_inv",    64'(bus.invalidate_from_other_cpu), 64'h0);
    check("t1_dsel_resp", 64'(bus.cpu_datasel), 64'h1);
    check("t1_boci_resp", 64'(bus.BOCI[25:13]), 64'h0A5);
    tick();
    check("t1_grant",  64'(bus.grant), 64'h1);
    check("t1_dsel",   64'(bus.cpu_datasel), 64'h1);
    check("t1_boci_grant", 64'(bus.BOCI), 64'h0);
    check("t1_mre_off", 64'(bus.mem_re), 64'h0);

    // Memory traffic from the granted core; the other core's write must not leak.
    bus.u_re   = 2'b01;
    bus.u_addr = {11'h7FF, 11'h123};
    bus.u_we   = 2'b10;
    bus.d_line = {64'h1111_2222_3333_4444, 64'h0};
    #1;
    check("t4_maddr", 64'(bus.mem_addr), 64'h123);
    check("t4_mre",   64'(bus.mem_re), 64'h1);
    check("t4_mwe",   64'(bus.mem_we), 64'h0);
    check("t4_mwdata", bus.mem_wdata, 64'h0);
    check("t4_urdy_pre", 64'(bus.u_rdy), 64'h0);
    bus.mem_rdata = 64'hDEAD_BEEF_0123_4567;
    bus.mem_rdy   = 1'b1;
    #1;
    check("t4_urdy",  64'(bus.u_rdy), 64'h1);
    check("t4_rdata", bus.u_rd_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    bus.mem_rdy = 1'b0;
    bus.u_re    = '0;
    bus.u_we    = '0;
    #1;
    check("t4_urdy_drop", 64'(bus.u_rdy), 64'h0);
    bus.read_miss = '0;
    #1;
    check("t1_grant_tail", 64'(bus.grant), 64'h1);
    tick();
    check_idle("t1_end");

    // Core 1 write miss (read also raised: write wins), peer holds it modified.
    bus.BICO       = {13'h1F0F, 13'h0};
    bus.write_miss = 2'b10;
    bus.read_miss  = 2'b10;
    tick();
    check("t3_search", 64'(bus.cpu_search), 64'h1);
    check("t3_boci0",  64'(bus.BOCI[12:0]), 64'h1F0F);
    check("t3_boci1",  64'(bus.BOCI[25:13]), 64'h0);
    bus.cpu_search_found = 2'b01;
    bus.block_state      = 4'b0010;
    tick();
    check("t3_inv",       64'(bus.invalidate_from_other_cpu), 64'h1);
    check("t3_dsel_resp", 64'(bus.cpu_datasel), 64'h8);
    tick();
    check("t3_inv_off", 64'(bus.invalidate_from_other_cpu), 64'h0);
    check("t3_grant",   64'(bus.grant), 64'h2);
    check("t3_dsel",    64'(bus.cpu_datasel), 64'h8);
    bus.write_miss       = '0;
    bus.read_miss        = '0;
    bus.cpu_search_found = '0;
    bus.block_state      = '0;
    tick();
    check_idle("t3_end");

    // Core 0 invalidate, peer misses: no pulse, no data source.
    bus.BICO       = {13'h0, 13'h0042};
    bus.invalidate = 2'b01;
    tick();
    tick();
    check("t5_inv",       64'(bus.invalidate_from_other_cpu), 64'h0);
    check("t5_dsel_resp", 64'(bus.cpu_datasel), 64'h0);
    tick();
    check("t5_grant", 64'(bus.grant), 64'h1);
    check("t5_dsel",  64'(bus.cpu_datasel), 64'h0);
    bus.invalidate = '0;
    #1;
    check("t5_grant_tail", 64'(bus.grant), 64'h1);
    tick();
    check_idle("t5_end");

    // Contention: round-robin alternates starting from core 0.
    for (int r = 0; r < 3; r++) begin
      bus.read_miss = 2'b11;
      tick();
      tick();
      tick();
      check($sformatf("rr%0d_grant", r), 64'(bus.grant), 64'(rr_exp[r]));
      bus.read_miss = '0;
      tick();
      check($sformatf("rr%0d_release", r), 64'(bus.grant), 64'h0);
    end

    // Asynchronous reset in the middle of a memory read.
    bus.read_miss = 2'b01;
    tick();
    tick();
    tick();
    bus.u_re   = 2'b01;
    bus.u_addr = {11'h0, 11'h055};
    #1;
    check("rst_mre_before", 64'(bus.mem_re), 64'h1);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid");
    bus.u_re      = '0;
    bus.read_miss = 2'b11;
    tick();
    check("rst_hold_grant", 64'(bus.grant), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("rst_pref_grant", 64'(bus.grant), 64'h1);
    check("rst_pref_dsel",  64'(bus.cpu_datasel), 64'h1);
    bus.read_miss = '0;
    tick();
    check_idle("rst_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
